// File: rtl/act_buff_write_ctrl.sv
// Activation-buffer write controller: scatters an upstream stream of compressed
// activation words across nb_pe_row row SRAMs, row-major, starting at base_addr.
module act_buff_write_ctrl #(
   parameter int nb_pe_row            = 16,
   parameter int compressed_act_width = 17,
   parameter int mem_depth            = 768,
   parameter int addr_width           = $clog2(mem_depth)
) (
   input  logic                                                clk,
   input  logic                                                rst,
   input  logic                                                start,
   input  logic [addr_width-1:0]                               base_addr,
   input  logic [addr_width:0]                                 words_per_row,
   input  logic                                                act_valid,
   input  logic [compressed_act_width-1:0]                     act_data,
   output logic                                                act_ready,
   output logic [nb_pe_row-1:0]                                wEn_AH,
   output logic [nb_pe_row-1:0][addr_width-1:0]                wAddr,
   output logic [nb_pe_row-1:0][compressed_act_width-1:0]      mem_data_in_all_rows,
   output logic                                                busy,
   output logic                                                done
);

   localparam int                    row_w       = (nb_pe_row > 1) ? $clog2(nb_pe_row) : 1;
   localparam logic [row_w-1:0]      row_last_c  = row_w'(nb_pe_row - 1);
   localparam logic [addr_width:0]   depth_c     = (addr_width + 1)'(mem_depth);
   localparam logic [addr_width-1:0] addr_last_c = addr_width'(mem_depth - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state_r;
   state_t                  state_s;
   logic [addr_width:0]     len_r;
   logic [addr_width:0]     word_cnt_r;
   logic [row_w-1:0]        row_cnt_r;
   logic [addr_width-1:0]   addr_r;
   logic [addr_width:0]     len_s;
   logic [addr_width-1:0]   base_mod_s;
   logic                    accept_s;
   logic                    last_beat_s;

   // Job decode, beat acceptance and next-state logic
   always_comb begin
      len_s       = words_per_row;
      base_mod_s  = base_addr;
      accept_s    = act_valid && (state_r == LOAD);
      last_beat_s = 1'b0;
      state_s     = state_r;

      if (words_per_row > depth_c) begin
         len_s = depth_c;
      end else begin
         len_s = words_per_row;
      end

      // mem_depth exceeds half the address space, so one subtraction reduces any base
      if ({1'b0, base_addr} >= depth_c) begin
         base_mod_s = addr_width'({1'b0, base_addr} - depth_c);
      end else begin
         base_mod_s = base_addr;
      end

      if (accept_s && (row_cnt_r == row_last_c) &&
          (word_cnt_r == (len_r - (addr_width + 1)'(1)))) begin
         last_beat_s = 1'b1;
      end else begin
         last_beat_s = 1'b0;
      end

      case (state_r)
         IDLE: begin
            if (start) begin
               if (len_s == (addr_width + 1)'(0)) begin
                  state_s = DONE;
               end else begin
                  state_s = LOAD;
               end
            end else begin
               state_s = IDLE;
            end
         end
         LOAD: begin
            if (last_beat_s) begin
               state_s = DONE;
            end else begin
               state_s = LOAD;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State, job registers, row/word counters and status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         len_r      <= {(addr_width + 1){1'b0}};
         word_cnt_r <= {(addr_width + 1){1'b0}};
         row_cnt_r  <= {row_w{1'b0}};
         addr_r     <= {addr_width{1'b0}};
         act_ready  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state_r   <= state_s;
         act_ready <= (state_s == LOAD);
         busy      <= (state_s == LOAD);
         done      <= (state_s == DONE);
         if ((state_r == IDLE) && start) begin
            len_r      <= len_s;
            addr_r     <= base_mod_s;
            row_cnt_r  <= {row_w{1'b0}};
            word_cnt_r <= {(addr_width + 1){1'b0}};
         end else if (accept_s) begin
            if (row_cnt_r == row_last_c) begin
               row_cnt_r  <= {row_w{1'b0}};
               word_cnt_r <= word_cnt_r + (addr_width + 1)'(1);
               addr_r     <= (addr_r == addr_last_c) ? {addr_width{1'b0}}
                                                     : addr_r + addr_width'(1);
            end else begin
               row_cnt_r <= row_cnt_r + row_w'(1);
            end
         end
      end
   end

   // Registered write port; rows not written this cycle keep address and data
   always_ff @(posedge clk) begin
      if (rst) begin
         wEn_AH               <= {nb_pe_row{1'b0}};
         wAddr                <= {(nb_pe_row * addr_width){1'b0}};
         mem_data_in_all_rows <= {(nb_pe_row * compressed_act_width){1'b0}};
      end else begin
         wEn_AH <= {nb_pe_row{1'b0}};
         if (accept_s) begin
            wEn_AH[row_cnt_r]               <= 1'b1;
            wAddr[row_cnt_r]                <= addr_r;
            mem_data_in_all_rows[row_cnt_r] <= act_data;
         end
      end
   end

endmodule

// File: tb/tb_act_buff_write_ctrl.sv
// Randomized bench for act_buff_write_ctrl: a job-level model predicts every
// output each cycle, plus directed jobs with hand-computed expectations.
module tb_act_buff_write_ctrl;

   localparam int R  = 16;
   localparam int DW = 17;
   localparam int D  = 768;
   localparam int AW = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                    rst, start, act_valid;
   logic [AW-1:0]           base_addr;
   logic [AW:0]             words_per_row;
   logic [DW-1:0]           act_data;
   logic                    act_ready, busy, done;
   logic [R-1:0]            wEn_AH;
   logic [R-1:0][AW-1:0]    wAddr;
   logic [R-1:0][DW-1:0]    mem_data_in_all_rows;

   act_buff_write_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .words_per_row(words_per_row), .act_valid(act_valid), .act_data(act_data),
      .act_ready(act_ready), .wEn_AH(wEn_AH), .wAddr(wAddr),
      .mem_data_in_all_rows(mem_data_in_all_rows), .busy(busy), .done(done)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0, wr_cnt = 0, done_cnt = 0, ready_cnt = 0, done_cyc = 0;
   int row0_log[$];

   // job-level model: expected outputs after the next rising edge
   bit                   m_loading = 1'b0;
   int                   m_k = 0, m_total = 0, m_base = 0;
   logic                 exp_ready = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;
   logic [R-1:0]         exp_wen = '0;
   logic [R-1:0][AW-1:0] exp_addr = '0;
   logic [R-1:0][DW-1:0] exp_data = '0;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_step();
      int r, w, len;
      logic [R-1:0] wen_n;
      bit done_n;
      wen_n  = '0;
      done_n = 1'b0;
      if (rst) begin
         m_loading = 1'b0;
         exp_addr  = '0;
         exp_data  = '0;
      end else if (m_loading) begin
         if (act_valid) begin
            r = m_k % R;
            w = m_k / R;
            exp_addr[r] = AW'((m_base + w) % D);
            exp_data[r] = act_data;
            wen_n[r]    = 1'b1;
            m_k++;
            if (m_k == m_total) begin
               m_loading = 1'b0;
               done_n    = 1'b1;
            end
         end
      end else if (!exp_done && start) begin
         len    = (int'(words_per_row) < D) ? int'(words_per_row) : D;
         m_base = int'(base_addr) % D;
         if (len == 0) begin
            done_n = 1'b1;
         end else begin
            m_loading = 1'b1;
            m_k       = 0;
            m_total   = len * R;
         end
      end
      exp_wen   = wen_n;
      exp_done  = done_n;
      exp_ready = m_loading;
      exp_busy  = m_loading;
   endtask

   // compare every cycle on the falling edge, then advance the model
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         chk("act_ready", 512'(act_ready), 512'(exp_ready));
         chk("busy",      512'(busy),      512'(exp_busy));
         chk("done",      512'(done),      512'(exp_done));
         chk("wEn_AH",    512'(wEn_AH),    512'(exp_wen));
         chk("wAddr",     512'(wAddr),     512'(exp_addr));
         chk("wdata",     512'(mem_data_in_all_rows), 512'(exp_data));
         wr_cnt += $countones(wEn_AH);
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (act_ready) ready_cnt++;
         if (wEn_AH[0]) row0_log.push_back(int'(wAddr[0]));
         model_step();
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_job(input int base, input int wpr, input int pct, input bit seq,
                          input int repulse_at, input int rst_at);
      int kk, n, budget, d0;
      bit acc, aborted;
      budget = ((wpr < D) ? wpr : D) * R * 8 + 50;
      d0 = done_cnt;
      base_addr = AW'(base);
      words_per_row = (AW + 1)'(wpr);
      start = 1'b1;
      step();
      start = 1'b0;
      kk = 0; n = 0; aborted = 1'b0;
      while (done_cnt == d0 && n < budget && !aborted) begin
         act_valid = ($urandom_range(99) < pct);
         act_data  = seq ? DW'(kk) : DW'($urandom);
         if (repulse_at >= 0 && kk >= repulse_at && kk < repulse_at + 2) begin
            start = 1'b1;
            base_addr = AW'(base + 200);
         end
         if (rst_at >= 0 && kk == rst_at) rst = 1'b1;
         acc = act_valid && act_ready;
         step();
         n++;
         if (acc) kk++;
         start = 1'b0;
         if (rst) begin
            rst = 1'b0;
            aborted = 1'b1;
         end
      end
      act_valid = 1'b0;
      if (!aborted) begin
         n_cmp++;
         if (done_cnt == d0) begin
            n_err++;
            $display("FAIL job_timeout: got no done after %0d cycles, expected one done pulse", n);
         end
         repeat (2) step();
      end
   endtask

   initial begin
      int w0, r0, d0, cs;
      int exp_b[4];
      exp_b = '{766, 767, 0, 1};
      rst = 1'b1; start = 1'b0; act_valid = 1'b0;
      base_addr = '0; words_per_row = '0; act_data = '0;
      repeat (3) step();
      rst = 1'b0;
      step();
      chk("reset_wen", 512'(wEn_AH), 512'(0));

      // base 0, two words per row, data = beat index
      w0 = wr_cnt;
      run_job(0, 2, 100, 1'b1, -1, -1);
      chk("A_writes", 512'(wr_cnt - w0), 512'(32));
      chk("A_row15_addr", 512'(wAddr[15]), 512'(1));
      chk("A_row15_data", 512'(mem_data_in_all_rows[15]), 512'(31));
      chk("A_model_row0_data", 512'(exp_data[0]), 512'(16));

      // address wrap past mem_depth-1
      row0_log.delete();
      run_job(766, 4, 100, 1'b0, -1, -1);
      chk("B_row0_count", 512'(row0_log.size()), 512'(4));
      for (int i = 0; i < 4 && i < row0_log.size(); i++)
         chk("B_row0_addr", 512'(row0_log[i]), 512'(exp_b[i]));

      // zero-length job
      w0 = wr_cnt; r0 = ready_cnt; d0 = done_cnt;
      base_addr = AW'(9); words_per_row = '0;
      start = 1'b1; cs = cyc;
      step();
      start = 1'b0;
      repeat (4) step();
      chk("C_writes", 512'(wr_cnt - w0), 512'(0));
      chk("C_ready", 512'(ready_cnt - r0), 512'(0));
      chk("C_done_count", 512'(done_cnt - d0), 512'(1));
      chk("C_done_latency", 512'(done_cyc - cs), 512'(2));

      // random valid gaps
      w0 = wr_cnt;
      run_job(40, 3, 50, 1'b0, -1, -1);
      chk("D_writes", 512'(wr_cnt - w0), 512'(48));

      // start re-pulsed mid-job with another base
      row0_log.delete();
      run_job(100, 2, 100, 1'b0, 5, -1);
      chk("E_row0_count", 512'(row0_log.size()), 512'(2));
      if (row0_log.size() == 2) begin
         chk("E_row0_addr0", 512'(row0_log[0]), 512'(100));
         chk("E_row0_addr1", 512'(row0_log[1]), 512'(101));
      end

      // reset after 10 beats, then a fresh short job
      run_job(0, 2, 100, 1'b0, -1, 10);
      chk("F_wen_after_rst", 512'(wEn_AH), 512'(0));
      chk("F_busy_after_rst", 512'(busy), 512'(0));
      chk("F_ready_after_rst", 512'(act_ready), 512'(0));
      chk("F_addr_after_rst", 512'(wAddr), 512'(0));
      step();
      row0_log.delete();
      w0 = wr_cnt;
      run_job(5, 1, 100, 1'b0, -1, -1);
      chk("F_writes", 512'(wr_cnt - w0), 512'(16));
      chk("F_row0_count", 512'(row0_log.size()), 512'(1));
      if (row0_log.size() == 1) chk("F_row0_addr", 512'(row0_log[0]), 512'(5));

      // random jobs
      for (int j = 0; j < 6; j++)
         run_job($urandom_range(D - 1), $urandom_range(6), $urandom_range(100, 30),
                 1'b0, -1, -1);

      // words_per_row above mem_depth is clipped
      w0 = wr_cnt;
      run_job(700, 1000, 100, 1'b0, -1, -1);
      chk("H_writes", 512'(wr_cnt - w0), 512'(D * R));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
